reg_port_arbiter: RTL and testbench

//  Shares the single register-file port (addr/dataIn/writeEn/dataOut, registered read) between
//  two requesters: port A (I2C slave side) and port B (local controller, e.g. PWM sequencer).

---
 rtl/reg_port_arbiter_if.sv | 44 ++++
 rtl/reg_port_arbiter.sv | 118 +++++++++++
 tb/tb_reg_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_port_arbiter_if.sv
// Requester ports A and B plus the shared register-file port, bundled for the arbiter.
interface reg_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;
   logic              a_err;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;
   logic              b_err;

   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata, a_err,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata, b_err,
      output rf_addr, rf_wdata, rf_we,
      input  rf_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata, a_err,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata, b_err,
      input  rf_addr, rf_wdata, rf_we,
      output rf_rdata
   );
endinterface

// File: rtl/reg_port_arbiter.sv
// Two-port arbiter serialising accesses onto one registered-read register-file port.
// Handshake: x_req/x_we/x_addr/x_wdata are held stable until the one-cycle x_ack, which completes the access.
module reg_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 6,
   parameter int PRIO_A   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   reg_port_arbiter_if.slave bus,
   output logic [1:0]        state_o
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

   state_t            state_q;
   logic              gnt_b_q;
   logic              last_b_q;
   logic              we_q;
   logic [ADDR_W-1:0] rf_addr_q;
   logic [DATA_W-1:0] rf_wdata_q;
   logic              rf_we_q;
   logic              a_ack_q;
   logic [DATA_W-1:0] a_rdata_q;
   logic              a_err_q;
   logic              b_ack_q;
   logic [DATA_W-1:0] b_rdata_q;
   logic              b_err_q;

   logic              pick_b_d;
   logic              sel_we_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;
   logic              sel_in_range_d;
   logic              rf_in_range_d;
   logic [DATA_W-1:0] cap_rdata_d;

   always_comb begin
      // On a tie, round-robin hands the grant to whichever port did not win last time.
      if (PRIO_A != 0) pick_b_d = bus.b_req & ~bus.a_req;
      else             pick_b_d = bus.b_req & (~bus.a_req | ~last_b_q);
      sel_we_d       = pick_b_d ? bus.b_we    : bus.a_we;
      sel_addr_d     = pick_b_d ? bus.b_addr  : bus.a_addr;
      sel_wdata_d    = pick_b_d ? bus.b_wdata : bus.a_wdata;
      sel_in_range_d = ({1'b0, sel_addr_d} < NUM_REGS_W);
      rf_in_range_d  = ({1'b0, rf_addr_q} < NUM_REGS_W);
      cap_rdata_d    = (we_q | ~rf_in_range_d) ? '0 : bus.rf_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_b_q    <= 1'b0;
         last_b_q   <= 1'b1;
         we_q       <= 1'b0;
         rf_addr_q  <= '0;
         rf_wdata_q <= '0;
         rf_we_q    <= 1'b0;
         a_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         a_err_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         b_rdata_q  <= '0;
         b_err_q    <= 1'b0;
      end else begin
         rf_we_q <= 1'b0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.a_req | bus.b_req) begin
                  gnt_b_q    <= pick_b_d;
                  last_b_q   <= pick_b_d;
                  we_q       <= sel_we_d;
                  rf_addr_q  <= sel_addr_d;
                  rf_wdata_q <= sel_wdata_d;
                  rf_we_q    <= sel_we_d & sel_in_range_d;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: begin
               // Registered read data for rf_addr_q is valid during this cycle.
               if (gnt_b_q) begin
                  b_ack_q   <= 1'b1;
                  b_rdata_q <= cap_rdata_d;
                  b_err_q   <= ~rf_in_range_d;
               end else begin
                  a_ack_q   <= 1'b1;
                  a_rdata_q <= cap_rdata_d;
                  a_err_q   <= ~rf_in_range_d;
               end
               state_q <= ST_RESP;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.rf_addr  = rf_addr_q;
   assign bus.rf_wdata = rf_wdata_q;
   assign bus.rf_we    = rf_we_q;
   assign bus.a_ack    = a_ack_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.a_err    = a_err_q;
   assign bus.b_ack    = b_ack_q;
   assign bus.b_rdata  = b_rdata_q;
   assign bus.b_err    = b_err_q;
   assign state_o      = state_q;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: round-robin instance with scoreboard, plus a fixed-priority instance.
module tb_reg_port_arbiter;
   logic       clk;
   logic       rst_n;
   logic [1:0] state_rr;
   logic [1:0] state_pr;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   reg_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_rr ();
   reg_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_pr ();

   reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(6), .PRIO_A(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .bus(bus_rr), .state_o(state_rr));
   reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(6), .PRIO_A(1)) dut_pr (
      .clk(clk), .rst_n(rst_n), .bus(bus_pr), .state_o(state_pr));

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc++;

   // ---------------- register files (registered read) ----------------
   logic [7:0] rf_mem_rr [256] = '{default: 8'h00};
   logic [7:0] rf_mem_pr [256] = '{default: 8'h00};
   always @(posedge clk) begin
      if (bus_rr.rf_we) rf_mem_rr[bus_rr.rf_addr] <= bus_rr.rf_wdata;
      bus_rr.rf_rdata <= rf_mem_rr[bus_rr.rf_addr];
      if (bus_pr.rf_we) rf_mem_pr[bus_pr.rf_addr] <= bus_pr.rf_wdata;
      bus_pr.rf_rdata <= rf_mem_pr[bus_pr.rf_addr];
   end

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         t_req;
      bit         chk_lat;
   } txn_t;

   txn_t       a_q[$];
   txn_t       b_q[$];
   logic [7:0] mem [256] = '{default: 8'h00};
   int         wr_cnt = 0;
   int         wr_seen = 0;
   logic [7:0] last_wr_addr, last_wr_data;
   logic [7:0] hold_a, hold_b;
   logic       hold_a_err, hold_b_err;
   logic       prev_a_ack, prev_b_ack, prev_we;
   bit         log_en = 0;
   int         ack_port_q[$];
   int         ack_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic score(input bit is_b, input logic [7:0] rdata, input logic err);
      txn_t       t;
      logic       inr;
      logic [7:0] exp_rd;
      if ((is_b && b_q.size() == 0) || (!is_b && a_q.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ack: port %s acked with no outstanding request (cycle %0d)",
                  is_b ? "B" : "A", cyc);
         return;
      end
      if (is_b) t = b_q.pop_front();
      else      t = a_q.pop_front();
      inr    = (t.addr < 8'd6);
      exp_rd = (t.we || !inr) ? 8'h00 : mem[t.addr];
      chk(is_b ? "b_rdata" : "a_rdata", rdata, exp_rd);
      chk(is_b ? "b_err" : "a_err", err, !inr);
      if (t.we && inr) begin
         chk("rf_write_count", wr_cnt - wr_seen, 1);
         chk("rf_write_addr", last_wr_addr, t.addr);
         chk("rf_write_data", last_wr_data, t.wdata);
         mem[t.addr] = t.wdata;
      end else begin
         chk("rf_no_write", wr_cnt - wr_seen, 0);
      end
      wr_seen = wr_cnt;
      if (t.chk_lat) chk("ack_latency", cyc - t.t_req, 3);
      if (log_en) begin
         ack_port_q.push_back(int'(is_b));
         ack_cyc_q.push_back(cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_a = 8'h00; hold_a_err = 1'b0;
         hold_b = 8'h00; hold_b_err = 1'b0;
         prev_a_ack = 1'b0; prev_b_ack = 1'b0; prev_we = 1'b0;
         wr_seen = wr_cnt;
      end else begin
         if (bus_rr.rf_we) begin
            chk("rf_we_one_cycle", prev_we, 1'b0);
            wr_cnt++;
            last_wr_addr = bus_rr.rf_addr;
            last_wr_data = bus_rr.rf_wdata;
         end
         prev_we = bus_rr.rf_we;
         if (bus_rr.a_ack || bus_rr.b_ack) chk("single_ack", bus_rr.a_ack & bus_rr.b_ack, 1'b0);
         if (bus_rr.a_ack) begin
            chk("a_ack_pulse", prev_a_ack, 1'b0);
            score(1'b0, bus_rr.a_rdata, bus_rr.a_err);
            hold_a = bus_rr.a_rdata; hold_a_err = bus_rr.a_err;
         end else begin
            chk("a_resp_held", {bus_rr.a_err, bus_rr.a_rdata}, {hold_a_err, hold_a});
         end
         if (bus_rr.b_ack) begin
            chk("b_ack_pulse", prev_b_ack, 1'b0);
            score(1'b1, bus_rr.b_rdata, bus_rr.b_err);
            hold_b = bus_rr.b_rdata; hold_b_err = bus_rr.b_err;
         end else begin
            chk("b_resp_held", {bus_rr.b_err, bus_rr.b_rdata}, {hold_b_err, hold_b});
         end
         prev_a_ack = bus_rr.a_ack;
         prev_b_ack = bus_rr.b_ack;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_access(input bit is_b, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, input bit chk_lat);
      txn_t t;
      bit   got;
      t.we = we; t.addr = addr; t.wdata = wdata; t.t_req = cyc; t.chk_lat = chk_lat;
      if (is_b) begin
         bus_rr.b_we = we; bus_rr.b_addr = addr; bus_rr.b_wdata = wdata; bus_rr.b_req = 1'b1;
         b_q.push_back(t);
      end else begin
         bus_rr.a_we = we; bus_rr.a_addr = addr; bus_rr.a_wdata = wdata; bus_rr.a_req = 1'b1;
         a_q.push_back(t);
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         #1;
         got = is_b ? bus_rr.b_ack : bus_rr.a_ack;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: port %s got no ack, required within 40 cycles", is_b ? "B" : "A");
      end
      @(posedge clk);
      #1;
      if (is_b) bus_rr.b_req = 1'b0;
      else      bus_rr.a_req = 1'b0;
   endtask

   task automatic rand_access(input bit is_b, input bit chk_lat);
      int         r;
      logic [7:0] addr;
      r    = $urandom_range(0, 9);
      addr = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      do_access(is_b, 1'($urandom_range(0, 1)), addr, 8'($urandom_range(0, 255)), chk_lat);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int  k;
      int  a_n;
      int  b_n;
      bit  drop_a;
      bit  drop_b;

      rst_n = 1'b0;
      bus_rr.a_req = 0; bus_rr.a_we = 0; bus_rr.a_addr = 0; bus_rr.a_wdata = 0;
      bus_rr.b_req = 0; bus_rr.b_we = 0; bus_rr.b_addr = 0; bus_rr.b_wdata = 0;
      bus_pr.a_req = 0; bus_pr.a_we = 0; bus_pr.a_addr = 0; bus_pr.a_wdata = 0;
      bus_pr.b_req = 0; bus_pr.b_we = 0; bus_pr.b_addr = 0; bus_pr.b_wdata = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(1);

      // reset state
      chk("rst_state", state_rr, 2'd0);
      chk("rst_rf_addr", bus_rr.rf_addr, 8'h00);
      chk("rst_rf_wdata", bus_rr.rf_wdata, 8'h00);
      chk("rst_rf_we", bus_rr.rf_we, 1'b0);
      chk("rst_acks", {bus_rr.a_ack, bus_rr.b_ack, bus_pr.a_ack, bus_pr.b_ack}, 4'h0);
      chk("rst_rdata", {bus_rr.a_rdata, bus_rr.b_rdata}, 16'h0000);
      chk("rst_err", {bus_rr.a_err, bus_rr.b_err}, 2'b00);

      // directed: A write, A read back, B out-of-range write and read
      do_access(1'b0, 1'b1, 8'd2, 8'h5A, 1'b1);
      do_access(1'b0, 1'b0, 8'd2, 8'h00, 1'b1);
      do_access(1'b1, 1'b1, 8'd6, 8'hFF, 1'b1);
      do_access(1'b1, 1'b0, 8'd6, 8'h00, 1'b1);

      // both ports continuously requesting: strict alternation starting with A, acks 4 cycles apart
      ack_port_q.delete();
      ack_cyc_q.delete();
      log_en = 1;
      k = cyc;
      fork
         begin
            repeat (3) do_access(1'b0, 1'b0, 8'd2, 8'h00, 1'b0);
         end
         begin
            do_access(1'b1, 1'b1, 8'd3, 8'hC3, 1'b0);
            do_access(1'b1, 1'b0, 8'd3, 8'h00, 1'b0);
            do_access(1'b1, 1'b1, 8'd4, 8'h3C, 1'b0);
         end
      join
      log_en = 0;
      chk("rr_ack_total", ack_port_q.size(), 6);
      for (int i = 0; i < ack_port_q.size() && i < 6; i++) begin
         chk("rr_grant_order", ack_port_q[i], i % 2);
         chk("rr_ack_cycle", ack_cyc_q[i] - k, 3 + 4 * i);
      end

      // random single-port traffic with exact latency
      for (int i = 0; i < 40; i++) begin
         rand_access(1'($urandom_range(0, 1)), 1'b1);
         idle($urandom_range(0, 2));
      end

      // random concurrent traffic from both ports
      fork
         for (int i = 0; i < 30; i++) begin
            rand_access(1'b0, 1'b0);
            idle($urandom_range(0, 3));
         end
         for (int j = 0; j < 30; j++) begin
            rand_access(1'b1, 1'b0);
            idle($urandom_range(0, 3));
         end
      join

      // fixed priority instance: A held starves B until A drops
      bus_pr.a_we = 0; bus_pr.a_addr = 8'd1;
      bus_pr.b_we = 0; bus_pr.b_addr = 8'd4;
      bus_pr.a_req = 1'b1;
      bus_pr.b_req = 1'b1;
      k = cyc; a_n = 0; b_n = 0; drop_a = 0; drop_b = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         if (drop_a) begin bus_pr.a_req = 1'b0; drop_a = 0; end
         if (drop_b) begin bus_pr.b_req = 1'b0; drop_b = 0; end
         if (bus_pr.a_ack) begin
            chk("pr_a_ack_cycle", cyc - k, 3 + 4 * a_n);
            a_n++;
            if (a_n == 3) drop_a = 1;
         end
         if (bus_pr.b_ack) begin
            chk("pr_b_ack_cycle", cyc - k, 15);
            chk("pr_b_resp", {bus_pr.b_err, bus_pr.b_rdata}, 9'h000);
            b_n++;
            drop_b = 1;
         end
      end
      chk("pr_a_ack_count", a_n, 3);
      chk("pr_b_ack_count", b_n, 1);

      // reset during ISSUE of a write; data equals the model's so either outcome leaves it consistent
      bus_rr.a_we = 1'b1; bus_rr.a_addr = 8'd5; bus_rr.a_wdata = mem[5]; bus_rr.a_req = 1'b1;
      @(posedge clk);
      #2;
      chk("t6_issue_rf_we", bus_rr.rf_we, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rf_we", bus_rr.rf_we, 1'b0);
      chk("t6_rf_addr", bus_rr.rf_addr, 8'h00);
      chk("t6_rf_wdata", bus_rr.rf_wdata, 8'h00);
      chk("t6_acks", {bus_rr.a_ack, bus_rr.b_ack}, 2'b00);
      chk("t6_resp", {bus_rr.a_err, bus_rr.a_rdata, bus_rr.b_err, bus_rr.b_rdata}, 18'h0);
      chk("t6_state", state_rr, 2'd0);
      bus_rr.a_req = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(6);
      chk("t6_idle_after", state_rr, 2'd0);
      do_access(1'b1, 1'b0, 8'd2, 8'h00, 1'b1);
      idle(4);

      chk("a_queue_drained", a_q.size(), 0);
      chk("b_queue_drained", b_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
